if_fetch_stage: RTL and testbench

//  Instruction-fetch stage; upstream producer of the IF/ID instruction/PC pair that decode consumes.

---
 rtl/if_fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, pipelined imem requests, in-order fetch buffer
// and the IF/ID register with stall, flush and redirect handling.
module if_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    BUF_DEPTH  = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] ID_instr_o,
  output logic [DATA_WIDTH-1:0] ID_pc_o,
  output logic                  ID_valid_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

  // Program counter and request bookkeeping
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]      out_cnt_reg, out_cnt_next;
  logic [CNT_W-1:0]      drop_cnt_reg, drop_cnt_next;

  // Tag FIFO: address of every request still awaiting its response
  logic [DATA_WIDTH-1:0] tag_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      tag_wr_ptr_reg, tag_wr_ptr_next;
  logic [PTR_W-1:0]      tag_rd_ptr_reg, tag_rd_ptr_next;
  logic [DATA_WIDTH-1:0] tag_head;

  // Fetch buffer: returned words with their PCs, in program order
  logic [DATA_WIDTH-1:0] buf_instr_mem [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc_mem    [BUF_DEPTH];
  logic [PTR_W-1:0]      buf_wr_ptr_reg, buf_wr_ptr_next;
  logic [PTR_W-1:0]      buf_rd_ptr_reg, buf_rd_ptr_next;
  logic [CNT_W-1:0]      buf_cnt_reg, buf_cnt_next;

  // IF/ID register
  logic [DATA_WIDTH-1:0] id_instr_reg, id_pc_reg;
  logic                  id_valid_reg;

  logic [CNT_W:0] credit_used;
  logic           credit_ok;
  logic           issue;
  logic           resp;
  logic           resp_keep;
  logic           resp_drop;
  logic           buf_push;
  logic           buf_pop;
  logic           squash;
  logic           buf_empty;

  // Words already in the buffer count against credit even if popped this cycle,
  // which keeps the request decision independent of stall/flush timing.
  assign credit_used = {1'b0, out_cnt_reg} + {1'b0, buf_cnt_reg};
  assign credit_ok   = (credit_used < DEPTH_C);
  assign imem_req_o  = rst_n & ~redirect_i & credit_ok;
  assign imem_addr_o = pc_reg;

  assign issue     = imem_req_o & imem_ready_i;
  assign resp      = imem_rvalid_i & (out_cnt_reg != '0);
  assign resp_keep = resp & (drop_cnt_reg == '0);
  assign resp_drop = resp & (drop_cnt_reg != '0);
  assign tag_head  = tag_mem[tag_rd_ptr_reg];

  assign squash    = flush_i | redirect_i;
  assign buf_empty = (buf_cnt_reg == '0);
  assign buf_push  = resp_keep & ~redirect_i;
  assign buf_pop   = ~squash & ~stall_i & ~buf_empty;

  always_comb begin
    pc_next         = pc_reg;
    out_cnt_next    = out_cnt_reg + CNT_W'(issue) - CNT_W'(resp);
    drop_cnt_next   = drop_cnt_reg;
    tag_wr_ptr_next = tag_wr_ptr_reg + PTR_W'(issue);
    tag_rd_ptr_next = tag_rd_ptr_reg + PTR_W'(resp);
    buf_wr_ptr_next = buf_wr_ptr_reg + PTR_W'(buf_push);
    buf_rd_ptr_next = buf_rd_ptr_reg + PTR_W'(buf_pop);
    buf_cnt_next    = buf_cnt_reg + CNT_W'(buf_push) - CNT_W'(buf_pop);

    if (redirect_i) begin
      // Every request still outstanding after this edge belongs to the old path.
      pc_next         = redirect_pc_i;
      drop_cnt_next   = out_cnt_reg - CNT_W'(resp);
      buf_wr_ptr_next = '0;
      buf_rd_ptr_next = '0;
      buf_cnt_next    = '0;
    end else begin
      if (issue) begin
        pc_next = pc_reg + DATA_WIDTH'(4);
      end
      if (resp_drop) begin
        drop_cnt_next = drop_cnt_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      out_cnt_reg    <= '0;
      drop_cnt_reg   <= '0;
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
      buf_wr_ptr_reg <= '0;
      buf_rd_ptr_reg <= '0;
      buf_cnt_reg    <= '0;
    end else begin
      pc_reg         <= pc_next;
      out_cnt_reg    <= out_cnt_next;
      drop_cnt_reg   <= drop_cnt_next;
      tag_wr_ptr_reg <= tag_wr_ptr_next;
      tag_rd_ptr_reg <= tag_rd_ptr_next;
      buf_wr_ptr_reg <= buf_wr_ptr_next;
      buf_rd_ptr_reg <= buf_rd_ptr_next;
      buf_cnt_reg    <= buf_cnt_next;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[tag_wr_ptr_reg] <= pc_reg;
    end
    if (buf_push) begin
      buf_instr_mem[buf_wr_ptr_reg] <= imem_rdata_i;
      buf_pc_mem[buf_wr_ptr_reg]    <= tag_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr_reg <= NOP_INSTR;
      id_pc_reg    <= '0;
      id_valid_reg <= 1'b0;
    end else if (squash) begin
      id_instr_reg <= NOP_INSTR;
      id_pc_reg    <= '0;
      id_valid_reg <= 1'b0;
    end else if (stall_i) begin
      id_instr_reg <= id_instr_reg;
      id_pc_reg    <= id_pc_reg;
      id_valid_reg <= id_valid_reg;
    end else if (!buf_empty) begin
      id_instr_reg <= buf_instr_mem[buf_rd_ptr_reg];
      id_pc_reg    <= buf_pc_mem[buf_rd_ptr_reg];
      id_valid_reg <= 1'b1;
    end else begin
      id_instr_reg <= NOP_INSTR;
      id_pc_reg    <= '0;
      id_valid_reg <= 1'b0;
    end
  end

  assign ID_instr_o = id_instr_reg;
  assign ID_pc_o    = id_pc_reg;
  assign ID_valid_o = id_valid_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage: an in-order memory responder plus a
// program-order model of the fetch PC and of the instruction stream seen by decode.
module tb_if_fetch_stage;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] ID_instr_o, ID_pc_o;
  logic        ID_valid_o;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .DATA_WIDTH(32), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .ID_instr_o(ID_instr_o), .ID_pc_o(ID_pc_o), .ID_valid_o(ID_valid_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_valid  = 0;
  int          rv_pct   = 100;
  logic [31:0] exp_fetch_pc;
  logic [31:0] exp_id_pc;
  logic [31:0] pending [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1000;
  endfunction

  // One clock cycle: memory responder, PC model and IF/ID stream model.
  task automatic tick();
    logic        acc, rv, st, fl, rd, p_valid;
    logic [31:0] rpc, aaddr, p_instr, p_pc;
    #3;
    acc = imem_req_o & imem_ready_i;
    aaddr = imem_addr_o;
    rv = imem_rvalid_i;
    st = stall_i; fl = flush_i; rd = redirect_i; rpc = redirect_pc_i;
    p_instr = ID_instr_o; p_pc = ID_pc_o; p_valid = ID_valid_o;
    n_checks++;
    if (imem_addr_o !== exp_fetch_pc) begin
      n_errors++;
      $display("FAIL fetch_addr: got %h want %h", imem_addr_o, exp_fetch_pc);
    end
    if (rd) begin
      n_checks++;
      if (imem_req_o !== 1'b0) begin
        n_errors++;
        $display("FAIL req_on_redirect: got %b want 0", imem_req_o);
      end
    end
    @(posedge clk);
    #1;
    if (rv && pending.size() > 0) void'(pending.pop_front());
    if (acc) pending.push_back(aaddr);
    if (rd) exp_fetch_pc = rpc;
    else if (acc) exp_fetch_pc = exp_fetch_pc + 32'd4;

    n_checks++;
    if (fl || rd) begin
      if (ID_valid_o !== 1'b0 || ID_instr_o !== NOP || ID_pc_o !== 32'h0) begin
        n_errors++;
        $display("FAIL squash: got v=%b i=%h pc=%h want v=0 i=%h pc=0", ID_valid_o, ID_instr_o, ID_pc_o, NOP);
      end
    end else if (st) begin
      if (ID_valid_o !== p_valid || ID_instr_o !== p_instr || ID_pc_o !== p_pc) begin
        n_errors++;
        $display("FAIL stall_hold: got v=%b i=%h pc=%h want v=%b i=%h pc=%h",
                 ID_valid_o, ID_instr_o, ID_pc_o, p_valid, p_instr, p_pc);
      end
    end else if (ID_valid_o === 1'b1) begin
      if (ID_pc_o !== exp_id_pc || ID_instr_o !== mem_word(exp_id_pc)) begin
        n_errors++;
        $display("FAIL id_order: got pc=%h i=%h want pc=%h i=%h", ID_pc_o, ID_instr_o, exp_id_pc, mem_word(exp_id_pc));
      end
      exp_id_pc = exp_id_pc + 32'd4;
      n_valid++;
    end else if (ID_valid_o !== 1'b0 || ID_instr_o !== NOP || ID_pc_o !== 32'h0) begin
      n_errors++;
      $display("FAIL bubble: got v=%b i=%h pc=%h want v=0 i=%h pc=0", ID_valid_o, ID_instr_o, ID_pc_o, NOP);
    end
    if (rd) exp_id_pc = rpc;

    n_checks++;
    if (pending.size() > BUF_DEPTH) begin
      n_errors++;
      $display("FAIL credit: got %0d in flight want <= %0d", pending.size(), BUF_DEPTH);
    end

    if (pending.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pending[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom();
    end
  endtask

  task automatic model_restart();
    pending.delete();
    exp_fetch_pc = RESET_PC;
    exp_id_pc    = RESET_PC;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 0;
    imem_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_restart();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 0;
    imem_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (imem_req_o !== 1'b0 || ID_valid_o !== 1'b0 || ID_instr_o !== NOP || ID_pc_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_state: got req=%b v=%b i=%h pc=%h want 0 0 %h 0", imem_req_o, ID_valid_o, ID_instr_o, ID_pc_o, NOP);
    end
    rst_n = 1'b1;
    model_restart();
    #1;
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      n_errors++;
      $display("FAIL reset_release: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int start;
    start = n_valid;
    rv_pct = 100;
    repeat (40) tick();
    n_checks++;
    if (n_valid - start < 20) begin
      n_errors++;
      $display("FAIL stream_rate: got %0d instrs in 40 cycles want >= 20", n_valid - start);
    end
  endtask

  task automatic test_stall();
    logic got;
    apply_reset();
    rv_pct = 100;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (ID_valid_o === 1'b1 && ID_pc_o === 32'h8) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL stall_reach: got no valid pc 0x8 want pc 0x8 within 20 cycles");
    end
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (ID_valid_o !== 1'b1 || ID_pc_o !== 32'h8 || ID_instr_o !== mem_word(32'h8)) begin
        n_errors++;
        $display("FAIL stall_frozen: got v=%b pc=%h i=%h want 1 00000008 %h", ID_valid_o, ID_pc_o, ID_instr_o, mem_word(32'h8));
      end
    end
    stall_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      tick();
      if (ID_valid_o === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got || ID_pc_o !== 32'hC) begin
      n_errors++;
      $display("FAIL stall_resume: got v=%b pc=%h want 1 0000000c", ID_valid_o, ID_pc_o);
    end
  endtask

  task automatic test_redirect();
    logic got;
    logic [31:0] seen [$];
    rv_pct = 0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick();
      if (pending.size() == 2) got = 1'b1;
    end
    n_checks++;
    if (!got || imem_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL redirect_setup: got inflight=%0d req=%b want 2 0", pending.size(), imem_req_o);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    rv_pct = 100;
    for (int k = 0; k < 16 && seen.size() < 2; k++) begin
      tick();
      if (ID_valid_o === 1'b1) seen.push_back(ID_pc_o);
    end
    n_checks++;
    if (seen.size() < 2 || seen[0] !== 32'h100 || seen[1] !== 32'h104) begin
      n_errors++;
      $display("FAIL redirect_target: got %0d valid, first=%h second=%h want 00000100 00000104",
               seen.size(), (seen.size() > 0) ? seen[0] : 32'hx, (seen.size() > 1) ? seen[1] : 32'hx);
    end
  endtask

  task automatic test_ready_low();
    logic [31:0] addr0;
    imem_ready_i = 1'b0;
    rv_pct = 100;
    repeat (6) tick();
    addr0 = imem_addr_o;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== addr0 || ID_valid_o !== 1'b0 || ID_instr_o !== NOP) begin
        n_errors++;
        $display("FAIL ready_low: got req=%b addr=%h v=%b i=%h want 1 %h 0 %h",
                 imem_req_o, imem_addr_o, ID_valid_o, ID_instr_o, addr0, NOP);
      end
    end
    imem_ready_i = 1'b1;
  endtask

  task automatic test_flush_stall();
    logic [31:0] saved;
    rv_pct = 100;
    imem_ready_i = 1'b1;
    stall_i = 1'b1;
    repeat (4) tick();
    saved = exp_id_pc;
    flush_i = 1'b1;
    tick();
    n_checks++;
    if (ID_valid_o !== 1'b0 || ID_instr_o !== NOP || ID_pc_o !== 32'h0) begin
      n_errors++;
      $display("FAIL flush_wins: got v=%b i=%h pc=%h want 0 %h 0", ID_valid_o, ID_instr_o, ID_pc_o, NOP);
    end
    flush_i = 1'b0;
    stall_i = 1'b0;
    tick();
    n_checks++;
    if (ID_valid_o !== 1'b1 || ID_pc_o !== saved) begin
      n_errors++;
      $display("FAIL flush_keeps_buf: got v=%b pc=%h want 1 %h", ID_valid_o, ID_pc_o, saved);
    end
  endtask

  task automatic test_reset_midfetch();
    logic got;
    rv_pct = 0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick();
      if (pending.size() == 2) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL midfetch_setup: got inflight=%0d want 2", pending.size());
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req_o !== 1'b0 || ID_valid_o !== 1'b0 || ID_instr_o !== NOP || ID_pc_o !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset: got req=%b v=%b i=%h pc=%h want 0 0 %h 0", imem_req_o, ID_valid_o, ID_instr_o, ID_pc_o, NOP);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_restart();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_BAD0;
    rv_pct = 100;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (ID_valid_o === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got || ID_pc_o !== RESET_PC || ID_instr_o !== mem_word(RESET_PC)) begin
      n_errors++;
      $display("FAIL restart: got v=%b pc=%h i=%h want 1 %h %h", ID_valid_o, ID_pc_o, ID_instr_o, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  task automatic test_random();
    int          start;
    logic [31:0] tgt;
    apply_reset();
    rv_pct = 100;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    redirect_i = 1'b0;
    repeat (15) tick();
    n_checks++;
    if (exp_id_pc < 32'h8 || exp_id_pc > 32'h40) begin
      n_errors++;
      $display("FAIL pc_wrap: got next pc %h want stream wrapped into 00000008..00000040", exp_id_pc);
    end
    start = n_valid;
    rv_pct = 70;
    for (int k = 0; k < 400; k++) begin
      imem_ready_i = ($urandom_range(0, 9) < 7);
      stall_i      = ($urandom_range(0, 9) < 2);
      flush_i      = ($urandom_range(0, 19) == 0);
      redirect_i   = ($urandom_range(0, 24) == 0);
      tgt = $urandom();
      redirect_pc_i = tgt & 32'hFFFF_FFFC;
      tick();
    end
    stall_i = 0; flush_i = 0; redirect_i = 0; imem_ready_i = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (n_valid - start < 50) begin
      n_errors++;
      $display("FAIL random_progress: got %0d instrs want >= 50", n_valid - start);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_low();
    test_flush_stall();
    test_reset_midfetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
